// File: rtl/antares_hilo_unit.sv
// HI/LO owner for the EX stage: multi-cycle multiply, restoring divide, MTHI/MTLO.
// Define ANTARES_HILO_ACC_EN to enable MADD/MADDU/MSUB/MSUBU (otherwise opcodes 4-7 are illegal).
module antares_hilo_unit #(
    parameter int WIDTH        = 32,
    parameter int MULT_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             op_ready,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int DW      = 2 * WIDTH;
    localparam int CNT_MAX = (WIDTH > MULT_LATENCY) ? WIDTH : MULT_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MULT_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WRITE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;      // multiplicand, or dividend magnitude / quotient shift register
    logic [WIDTH-1:0] b_q, b_d;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             mul_signed_q, mul_signed_d;
    logic             neg_rem_q, neg_rem_d;
    logic             neg_quo_q, neg_quo_d;

    logic             accept;
    logic             is_mul_code;
    logic             div_neg_a, div_neg_b;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [DW-1:0]    mul_a_ext, mul_b_ext;
    logic [DW-1:0]    product;
    logic [DW-1:0]    mul_res;

    assign accept    = op_valid & (state_q == S_IDLE) & ~flush;
    assign div_neg_a = ~op_code[0] & op_a[WIDTH-1];
    assign div_neg_b = ~op_code[0] & op_b[WIDTH-1];
    assign div_shift = {rem_q, a_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
    assign mul_a_ext = {{WIDTH{mul_signed_q & a_q[WIDTH-1]}}, a_q};
    assign mul_b_ext = {{WIDTH{mul_signed_q & b_q[WIDTH-1]}}, b_q};
    assign product   = mul_a_ext * mul_b_ext;

`ifdef ANTARES_HILO_ACC_EN
    logic [1:0] acc_q, acc_d;   // bit 0: accumulate, bit 1: subtract

    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = (op_code[3:2] == 2'b01) ? {op_code[1], ~op_code[1]} : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= 2'b00;
        else     acc_q <= acc_d;
    end

    always_comb begin
        mul_res = product;
        if (acc_q[0])      mul_res = {hi_q, lo_q} + product;
        else if (acc_q[1]) mul_res = {hi_q, lo_q} - product;
    end

    assign is_mul_code = (op_code[3:1] == 3'b000) || (op_code[3:2] == 2'b01);
`else
    assign mul_res     = product;
    assign is_mul_code = (op_code[3:1] == 3'b000);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        rem_d        = rem_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        done_d       = 1'b0;
        dbz_d        = 1'b0;
        mul_signed_d = mul_signed_q;
        neg_rem_d    = neg_rem_q;
        neg_quo_d    = neg_quo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                    done_d  = 1'b1;
                    if (is_mul_code) begin
                        state_d      = S_MUL;
                        done_d       = 1'b0;
                        a_d          = op_a;
                        b_d          = op_b;
                        mul_signed_d = ~op_code[0];
                    end else if (op_code[3:1] == 3'b001) begin
                        if (op_b == '0) begin
                            dbz_d = 1'b1;
                        end else begin
                            state_d   = S_DIV;
                            done_d    = 1'b0;
                            a_d       = div_neg_a ? -op_a : op_a;
                            b_d       = div_neg_b ? -op_b : op_b;
                            rem_d     = '0;
                            neg_rem_d = div_neg_a;
                            neg_quo_d = div_neg_a ^ div_neg_b;
                        end
                    end else if (op_code == 4'd8) begin
                        hi_d = op_a;
                    end else if (op_code == 4'd9) begin
                        lo_d = op_a;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = S_WRITE;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Remainder stays below the divisor, so the difference always fits WIDTH bits.
                    rem_d = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], div_ge};
                    if (cnt_q == DIV_LAST) state_d = S_FIX;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = neg_rem_q ? -rem_q : rem_q;
                    lo_d    = neg_quo_q ? -a_q : a_q;
                    state_d = S_WRITE;
                    done_d  = 1'b1;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
            mul_signed_q <= 1'b0;
            neg_rem_q    <= 1'b0;
            neg_quo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rem_q        <= rem_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            done_q       <= done_d;
            dbz_q        <= dbz_d;
            mul_signed_q <= mul_signed_d;
            neg_rem_q    <= neg_rem_d;
            neg_quo_q    <= neg_quo_d;
        end
    end

    assign op_ready    = (state_q == S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: doc/antares_hilo_unit.md
# antares_hilo_unit

- Parametrised multi-cycle multiply/divide engine that owns the HI/LO register pair for the Antares EX stage.
- Replaces the ad-hoc multiplier/divider/HILO glue currently inside the ALU with a single block: configurable data width and multiplier latency, explicit valid/ready start handshake, flush abort, completion pulse and divide-by-zero flag.
- The ALU issues one HILO operation at a time and stalls on `op_ready`.

## Interface

Parameters:

- `WIDTH`, 32, operand width; even, >= 8; HI and LO are each `WIDTH` bits.
- `MULT_LATENCY`, 3, multiplier cycles (>= 1) from acceptance to result capture.

Ports:

- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `op_valid` in 1: operation request.
- `op_code` in 4: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, 10–15 illegal.
- `op_a` in WIDTH: multiplicand / dividend / MT source.
- `op_b` in WIDTH: multiplier / divisor.
- `flush` in 1: abort request and in-flight operation.
- `op_ready` out 1: block idle, request will be accepted.
- `done` out 1: one-cycle pulse; new HI/LO (or final status) visible this cycle.
- `div_by_zero` out 1: one-cycle pulse coincident with `done` for DIV/DIVU with `op_b`==0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation

- **States:** IDLE, MUL, DIV, FIX, WRITE.
  - `op_ready` = (state==IDLE); it is a function of state only, never of `op_valid`.
- **Accept** = `op_valid & op_ready & ~flush`; operands and opcode are latched at the accept edge.
- **MULT/MULTU/MADD*/MSUB*:** IDLE→MUL for `MULT_LATENCY` cycles, then →WRITE, then →IDLE.
  - Product is signed for MULT/MADD/MSUB, unsigned otherwise; product width is 2·WIDTH.
  - MADD*: {hi,lo} += product. MSUB*: {hi,lo} −= product. Both wrap modulo 2^(2·WIDTH).
- **DIV/DIVU (divisor ≠ 0):** IDLE→DIV, one restoring quotient bit per cycle, WIDTH cycles on magnitudes; →FIX for one cycle of sign correction; →WRITE.
  - lo = quotient, truncated toward zero; hi = remainder, carrying the dividend's sign.
  - Most-negative ÷ −1: lo = most-negative, hi = 0; no trap.
- **DIV/DIVU with `op_b`==0:** IDLE→WRITE with no HI/LO change; `div_by_zero` pulses.
- **MTHI/MTLO:** hi (resp. lo) ← `op_a` at the accept edge; →WRITE for completion only.
- **Illegal opcodes:** accepted; →WRITE with no HI/LO change.
- **WRITE:** HI/LO are updated at the edge leaving the final compute state; `done` is registered and high during WRITE.
- **Flush:**
  - In any non-IDLE state: next state is IDLE; no HI/LO write, no `done`, no `div_by_zero`.
  - Flush in the final compute cycle suppresses the write; flush has priority over completion.
  - Flush during WRITE does not undo the already-committed HI/LO.
- **Reset mid-operation:** state→IDLE, hi=lo=0, `done`=`div_by_zero`=0, `op_ready`=1 in the cycle after the reset edge.

## Timing

- **Reset values:** `hi`=0, `lo`=0, `done`=0, `div_by_zero`=0, `op_ready`=1.
- **Latency**, counted in cycles after the accept edge, to the cycle in which `done`=1 and results are visible:
  - MUL family: `MULT_LATENCY`+1 (4 at default).
  - DIV/DIVU: WIDTH+2 (34 at default).
  - MTHI/MTLO, divide-by-zero, illegal: 1.
- `op_ready` rises in the cycle after WRITE; throughput is one operation per latency+1 cycles.
- `op_valid` held while `op_ready`=0 is ignored; the requester keeps it asserted until it sees acceptance.
- `hi`/`lo` are stable outside update edges and are readable (MFHI/MFLO) in any state. Readers gate on `op_ready` for coherence.

## Configuration

- **`ANTARES_HILO_ACC_EN` defined:** MADD/MADDU/MSUB/MSUBU behave as above.
- **`ANTARES_HILO_ACC_EN` undefined:**
  - Opcodes 4–7 are treated as illegal (1-cycle `done`, HI/LO unchanged).
  - The 2·WIDTH adder/subtractor is not synthesised.

## Test plan

All scenarios use WIDTH=32, MULT_LATENCY=3.

- **MULT:** `op_a`=0xFFFFFFFF, `op_b`=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done` 4 cycles after accept; MULTU with same operands → hi=0x00000001, lo=0xFFFFFFFE.
- **DIV:** −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, `done` 34 cycles after accept; DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- **DIVU by zero:** 5 ÷ 0 with prior hi/lo = 1/2 → `done`=`div_by_zero`=1 one cycle after accept, hi/lo stay 1/2.
- **Accumulate:** MTLO 5, MTHI 0, then MADD 3×4 → lo=0x11, hi=0; MSUBU 1×0x12 → hi=0xFFFFFFFF, lo=0xFFFFFFFF. Without `ANTARES_HILO_ACC_EN`, the MADD leaves lo=5.
- **Flush:** flush 10 cycles into a DIV → `op_ready`=1 next cycle, no `done`, hi/lo unchanged; flush in the final MUL cycle → no write.
- **Reset and ready handling:** `rst` asserted mid-MUL → next cycle hi=lo=0, `op_ready`=1. `op_valid` held while busy → exactly one operation executes.
